// File: rtl/ctrl_decode.sv
// ctrl_decode: same-cycle instruction decode for the fetch unit, with a small
// FSM for two-word instructions, halt and start-up, plus a retired-instruction counter.
`default_nettype none

module ctrl_decode #(
  parameter int IW   = 9,
  parameter int PCW  = 16,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            Init,
  input  logic [IW-1:0]   Instr,
  output logic            Branch_abs,
  output logic            Branch_rel_z,
  output logic            Branch_rel_nz,
  output logic [PCW-1:0]  Target,
  output logic [2:0]      Alu_op,
  output logic [2:0]      Reg_addr,
  output logic            Reg_we,
  output logic [PCW-1:0]  Imm,
  output logic            Imm_we,
  output logic            Halt,
  output logic [CNTW-1:0] Icount
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_EXT    = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam logic [2:0] OP_ALU  = 3'b000;
  localparam logic [2:0] OP_LDIS = 3'b001;
  localparam logic [2:0] OP_BZ   = 3'b010;
  localparam logic [2:0] OP_BNZ  = 3'b011;
  localparam logic [2:0] OP_JMPL = 3'b100;
  localparam logic [2:0] OP_LDIL = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  logic [1:0]      state_q,    state_d;
  logic [5:0]      hi6_q,      hi6_d;
  logic            long_jmp_q, long_jmp_d;
  logic            halt_q,     halt_d;
  logic [CNTW-1:0] icount_q,   icount_d;
  logic            w_retire;

  logic [2:0]     w_op;
  logic [5:0]     w_opd;
  logic [PCW-1:0] w_sext;
  logic [PCW-1:0] w_ext_val;

  assign w_op      = Instr[8:6];
  assign w_opd     = Instr[5:0];
  assign w_sext    = {{(PCW-6){w_opd[5]}}, w_opd};
  // Second word of a long op is pure data: the top bit stays zero.
  assign w_ext_val = {{(PCW-IW-6){1'b0}}, hi6_q, Instr};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      hi6_q      <= 6'd0;
      long_jmp_q <= 1'b0;
      halt_q     <= 1'b0;
      icount_q   <= '0;
    end else begin
      state_q    <= state_d;
      hi6_q      <= hi6_d;
      long_jmp_q <= long_jmp_d;
      halt_q     <= halt_d;
      icount_q   <= icount_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hi6_d      = hi6_q;
    long_jmp_d = long_jmp_q;
    halt_d     = halt_q;
    w_retire   = 1'b0;
    if (Init) begin
      state_d    = S_RUN;
      hi6_d      = 6'd0;
      long_jmp_d = 1'b0;
      halt_d     = 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          case (w_op)
            OP_JMPL: begin
              hi6_d      = w_opd;
              long_jmp_d = 1'b1;
              state_d    = S_EXT;
            end
            OP_LDIL: begin
              hi6_d      = w_opd;
              long_jmp_d = 1'b0;
              state_d    = S_EXT;
            end
            OP_HALT: begin
              state_d  = S_HALTED;
              halt_d   = 1'b1;
              w_retire = 1'b1;
            end
            default: w_retire = 1'b1;
          endcase
        end
        S_EXT: begin
          state_d  = S_RUN;
          w_retire = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if (Init)
      icount_d = '0;
    else if (w_retire && (icount_q != CNT_MAX))
      icount_d = icount_q + 1'b1;
    else
      icount_d = icount_q;
  end

  always_comb begin
    Branch_abs    = 1'b0;
    Branch_rel_z  = 1'b0;
    Branch_rel_nz = 1'b0;
    Target        = '0;
    Alu_op        = 3'd0;
    Reg_addr      = 3'd0;
    Reg_we        = 1'b0;
    Imm           = '0;
    Imm_we        = 1'b0;
    if (!Init) begin
      case (state_q)
        S_RUN: begin
          case (w_op)
            OP_ALU: begin
              Alu_op   = w_opd[5:3];
              Reg_addr = w_opd[2:0];
              Reg_we   = 1'b1;
            end
            OP_LDIS: begin
              Imm    = w_sext;
              Imm_we = 1'b1;
            end
            OP_BZ: begin
              Branch_rel_z = 1'b1;
              Target       = w_sext;
            end
            OP_BNZ: begin
              Branch_rel_nz = 1'b1;
              Target        = w_sext;
            end
            default: ;
          endcase
        end
        S_EXT: begin
          if (long_jmp_q) begin
            Branch_abs = 1'b1;
            Target     = w_ext_val;
          end else begin
            Imm    = w_ext_val;
            Imm_we = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Halt   = halt_q;
  assign Icount = icount_q;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_decode.sv
// tb_ctrl_decode: directed and random stimulus against a behavioural model,
// with a queue-based scoreboard and an independent monitor.
`default_nettype none

module tb_ctrl_decode;

  localparam int CNTW = 5;
  localparam int CMAX = (1 << CNTW) - 1;

  typedef struct packed {
    logic            ba;
    logic            rz;
    logic            rnz;
    logic [15:0]     tgt;
    logic [2:0]      alu;
    logic [2:0]      ra;
    logic            rwe;
    logic [15:0]     imm;
    logic            imwe;
    logic            halt;
    logic [CNTW-1:0] cnt;
  } exp_t;

  logic            clk = 1'b0;
  logic            RST_N = 1'b0;
  logic            Init = 1'b0;
  logic [8:0]      Instr = 9'd0;
  logic            Branch_abs, Branch_rel_z, Branch_rel_nz, Reg_we, Imm_we, Halt;
  logic [15:0]     Target, Imm;
  logic [2:0]      Alu_op, Reg_addr;
  logic [CNTW-1:0] Icount;

  ctrl_decode #(.IW(9), .PCW(16), .CNTW(CNTW)) dut (
    .CLK(clk), .RST_N(RST_N), .Init(Init), .Instr(Instr),
    .Branch_abs(Branch_abs), .Branch_rel_z(Branch_rel_z), .Branch_rel_nz(Branch_rel_nz),
    .Target(Target), .Alu_op(Alu_op), .Reg_addr(Reg_addr), .Reg_we(Reg_we),
    .Imm(Imm), .Imm_we(Imm_we), .Halt(Halt), .Icount(Icount)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: program running?, halted?, pending long op (0 none, 1 jump, 2 load)
  bit m_started = 0;
  bit m_halted  = 0;
  int m_pend    = 0;
  int m_hi      = 0;
  bit m_halt_r  = 0;
  int m_cnt     = 0;

  task automatic model_reset();
    m_started = 0; m_halted = 0; m_pend = 0; m_hi = 0; m_halt_r = 0; m_cnt = 0;
  endtask

  function automatic void bump();
    if (m_cnt < CMAX) m_cnt = m_cnt + 1;
  endfunction

  task automatic cycle(input bit rst, input bit init, input int instr, input bit mid_rst = 0);
    exp_t e;
    int op, opd, sx, val;
    @(negedge clk);
    RST_N = rst; Init = init; Instr = instr[8:0];
    if (!rst) model_reset();
    e = '0;
    e.halt = m_halt_r;
    e.cnt  = m_cnt[CNTW-1:0];
    if (rst) begin
      op  = (instr >> 6) & 7;
      opd = instr & 63;
      sx  = (opd >= 32) ? opd - 64 : opd;
      if (init) begin
        m_started = 1; m_halted = 0; m_pend = 0; m_hi = 0; m_halt_r = 0; m_cnt = 0;
      end else if (m_started && !m_halted) begin
        if (m_pend != 0) begin
          val = m_hi * 512 + (instr & 511);
          if (m_pend == 1) begin e.ba = 1; e.tgt = val[15:0]; end
          else begin e.imm = val[15:0]; e.imwe = 1; end
          m_pend = 0;
          bump();
        end else begin
          case (op)
            0: begin e.alu = 3'(opd / 8); e.ra = 3'(opd % 8); e.rwe = 1; bump(); end
            1: begin e.imm = 16'(sx); e.imwe = 1; bump(); end
            2: begin e.rz = 1; e.tgt = 16'(sx); bump(); end
            3: begin e.rnz = 1; e.tgt = 16'(sx); bump(); end
            4: begin m_pend = 1; m_hi = opd; end
            5: begin m_pend = 2; m_hi = opd; end
            6: begin m_halted = 1; m_halt_r = 1; bump(); end
            default: bump();
          endcase
        end
      end
    end
    sb.push_back(e);
    if (mid_rst) begin
      #4;
      RST_N = 0;
      model_reset();
    end
  endtask

  // Monitor: samples every negedge+3, well clear of the posedge
  initial begin
    exp_t w, g;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        w = sb.pop_front();
        g = {Branch_abs, Branch_rel_z, Branch_rel_nz, Target, Alu_op, Reg_addr,
             Reg_we, Imm, Imm_we, Halt, Icount};
        n_vec++;
        if (g !== w) begin
          n_bad++;
          $display("FAIL outputs vec%0d t=%0t: got ba=%b rz=%b rnz=%b tgt=%h alu=%0d ra=%0d we=%b imm=%h iwe=%b halt=%b cnt=%0d; want ba=%b rz=%b rnz=%b tgt=%h alu=%0d ra=%0d we=%b imm=%h iwe=%b halt=%b cnt=%0d",
                   n_vec, $time, g.ba, g.rz, g.rnz, g.tgt, g.alu, g.ra, g.rwe, g.imm, g.imwe, g.halt, g.cnt,
                   w.ba, w.rz, w.rnz, w.tgt, w.alu, w.ra, w.rwe, w.imm, w.imwe, w.halt, w.cnt);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    cycle(0, 0, 0);
    cycle(0, 0, 'h1FF);
    cycle(1, 0, 'h0C5);
    cycle(1, 0, 'h0C5);
    cycle(1, 1, 'h1C5);
    cycle(1, 0, 'h1C5);
    cycle(1, 0, 'h0BD);
    cycle(1, 0, 'h0FF);
    cycle(1, 0, 'h101);
    cycle(1, 0, 'h023);
    cycle(1, 0, 'h023);
    cycle(1, 0, 'h17F);
    cycle(1, 0, 'h1FF);
    cycle(1, 0, 'h05F);
    cycle(1, 0, 'h180);
    cycle(1, 0, 'h000);
    cycle(1, 0, 'h101);
    cycle(1, 1, 'h180);
    cycle(1, 0, 'h1C5);
    cycle(1, 0, 'h180, 1);
    cycle(0, 0, 'h000);
    cycle(1, 0, 'h000);
    cycle(1, 1, 'h000);
    cycle(1, 0, 'h101, 1);
    cycle(0, 0, 'h023);
    cycle(1, 1, 'h000);
    cycle(1, 0, 'h023);
    cycle(1, 0, 'h17F);
    cycle(1, 1, 'h1FF);
    cycle(1, 0, 'h1FF);
    for (int i = 0; i < CMAX + 6; i++) cycle(1, 0, 'h1C0);
    cycle(1, 0, 'h101);
    cycle(1, 0, 'h000);
    cycle(1, 0, 'h180);
    cycle(1, 0, 'h000);
    cycle(1, 1, 'h000);
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 24) == 0),
            int'($urandom_range(0, 511)), ($urandom_range(0, 99) == 0));
    end
    cycle(1, 0, 'h1C0);
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #5;
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
